seg_capture: RTL and testbench
==============================

# seg_capture

Seven-segment capture decoder: samples a time-multiplexed, active-low seven-segment bus (`seg`/`an`) and reconstructs the four 4-bit digit codes being displayed. It is the inverse of the display driver. It sits on the display pins in loopback for board self-test and as a bench monitor. Digits are published coherently once per complete mux frame.

## Interface
- `SETTLE`, 4: consecutive cycles the registered bus must be unchanged before it is sampled (≥1).
- `STALE`, 200000: cycles without a valid sample before the frame is declared lost.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `seg_in` in 7: segments `{g,f,e,d,c,b,a}`, active low.
- `an_in` in 4: anodes, active low; bit 3 is the leftmost digit.
- `digit3`..`digit0` out 4 each: captured codes (0-9, C=4'hC, h=4'hD, dash=4'hE, blank=4'hF).
- `frame_valid` out 1: level; the digits reflect a complete, current frame.
- `frame_pulse` out 1: one-cycle strobe when new digits are loaded.
- `bad_seg` out 1: one-cycle strobe; the sampled pattern is not in the code table.
- `an_err` out 1: one-cycle strobe; more than one anode is active.

## Operation
- One input register stage holds `{an_in, seg_in}` in `in_q`. The previous value is held in `in_prev`.
- Stability counter `cnt`:
  - Clears when `in_q != in_prev`.
  - Otherwise increments, saturating at `SETTLE`.
  - The sample strobe fires on the single cycle where `cnt` reaches `SETTLE`.
  - It fires once per stable period; repeated stable cycles do not re-sample.
- Actions on the sample strobe, based on `an` in `in_q`:
  - `4'b1111`: ignored. No write, no error.
  - Exactly one bit low at index i: decode `seg`.
    - If the pattern is valid, write the code into `store[i]` and set `seen[i]`.
    - If the pattern is unknown, pulse `bad_seg`; `store` and `seen` are unchanged.
  - Two or more bits low: pulse `an_err`; nothing is written.
- Code table:
  - Patterns for 0-9 decode to 0-9. `S` is identical to 5 and `O` is identical to 0, so they decode to 5 and 0.
  - `7'b1000110` decodes to C.
  - `7'b0001011` decodes to h.
  - `7'b0111111` decodes to dash.
  - `7'b1111111` decodes to blank.
  - Every other pattern is invalid.
- Frame completion: when `seen`, including the current write, equals `4'b1111`:
  - `digit3..0` load from `store`, including the new value.
  - `seen` clears.
  - `frame_valid` sets.
  - `frame_pulse` goes high for one cycle.
- Rewriting the same position before the frame completes overwrites `store[i]`; the last value wins.
- Watchdog `idle_cnt`:
  - Clears on each valid write.
  - Saturates at `STALE`.
  - On reaching `STALE`, `frame_valid` clears and `seen` clears. The digits hold their last values.
- Reset mid-operation discards partial frames.

## Timing
- Reset values:
  - `digit3..0 = 4'hF`.
  - `frame_valid`, `frame_pulse`, `bad_seg`, `an_err` = 0.
  - `seen = 0`, `cnt = 0`, `idle_cnt = 0`.
- Bus change at input edge N:
  - `in_q` updates at edge N+1.
  - The sample strobe is true in the cycle after edge N+SETTLE.
  - The write, digit load and error pulses register at edge N+SETTLE+1.
- `frame_pulse` and the error strobes are exactly one cycle wide.
- Any bus change shorter than `SETTLE` cycles produces no sample.
- Simultaneous frame completion and watchdog expiry: completion wins; `frame_valid` stays 1 and `idle_cnt` clears.

## Configuration
- `SEG_CAPTURE_DP_EN` defined:
  - Adds input `dp_in` (1 bit, active low), included in the stability compare.
  - Adds output `dp_pos` [3:0]: bit i is set if dp was active at position i in the last completed frame.
  - `dp_pos` resets to 0 and loads with the digits.
- `SEG_CAPTURE_DP_EN` undefined: neither port exists and dp is not observed.

## Structure
- Package `seg_pkg` holds:
  - Segment pattern constants for 0-9, C, h, dash and blank, shared with the display driver.
  - Code constants `CODE_C`, `CODE_H`, `CODE_DASH`, `CODE_BLANK`.
- Sub-module `seg_pattern_decode`: combinational, 7-bit pattern in, 4-bit code plus `valid` out.
- The top level holds the input register, stability counter, store/`seen`, watchdog and output registers.

## Test plan
- Reset held for 3 cycles, then released with no bus activity → `digit3..0 = F,F,F,F`; `frame_valid = 0`; no strobes.
- Display driver in loopback showing 1,2,3,4, `SETTLE = 4` → one `frame_pulse` after the fourth anode slot; `digit3..0 = 1,2,3,4`; `frame_valid = 1`.
- Digit pattern `7'b0010010` (S) at `an = 4'b1110`, held 2 cycles then changed, `SETTLE = 4` → no write, no strobe. The same pattern held 6 cycles → `store[0] = 5`.
- Pattern `7'b1010101` at `an = 4'b1101`, stable → `bad_seg` high for one cycle; `seen[1]` stays 0; no `frame_pulse`.
- `an = 4'b1100`, stable → one `an_err` pulse; nothing written.
- After a valid frame, the bus is frozen at `an = 4'b1111` for `STALE` cycles → `frame_valid` drops to 0; the digits keep their last values.

Source files
------------

// File: rtl/seg_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg_pkg : segment patterns ({g,f,e,d,c,b,a}, active low) and digit codes
// Rev 1.0
// ----------------------------------------------------------------------------
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_H     = 7'b0001011;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_C     = 4'hC;
  localparam logic [3:0] CODE_H     = 4'hD;
  localparam logic [3:0] CODE_DASH  = 4'hE;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } bus_t;

  typedef enum logic [1:0] {
    AN_NONE  = 2'd0,
    AN_ONE   = 2'd1,
    AN_MULTI = 2'd2
  } an_class_e;

  function automatic an_class_e classify_an(input logic [3:0] an);
    logic [2:0] lows;
    lows = '0;
    for (int k = 0; k < 4; k++) lows = lows + {2'b00, ~an[k]};
    if (lows == 3'd0) return AN_NONE;
    if (lows == 3'd1) return AN_ONE;
    return AN_MULTI;
  endfunction

  // Only meaningful when exactly one anode is low.
  function automatic logic [1:0] an_index(input logic [3:0] an);
    if (!an[0]) return 2'd0;
    if (!an[1]) return 2'd1;
    if (!an[2]) return 2'd2;
    return 2'd3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_pattern_decode.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg_pattern_decode : combinational segment pattern to digit code lookup
// Rev 1.0
// ----------------------------------------------------------------------------
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] code,
  output logic       valid
);

  always_comb begin
    code  = CODE_BLANK;
    valid = 1'b1;
    case (pattern)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_C:     code = CODE_C;
      SEG_H:     code = CODE_H;
      SEG_DASH:  code = CODE_DASH;
      SEG_BLANK: code = CODE_BLANK;
      default:   valid = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_capture.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg_capture : rebuilds four digit codes from a multiplexed seven-segment bus
// Optional SEG_CAPTURE_DP_EN adds dp_in / dp_pos.  Rev 1.0
// ----------------------------------------------------------------------------
module seg_capture
  import seg_pkg::*;
#(
  parameter int SETTLE = 4,
  parameter int STALE  = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic [3:0] an_in,
`ifdef SEG_CAPTURE_DP_EN
  input  logic       dp_in,
  output logic [3:0] dp_pos,
`endif
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic       frame_valid,
  output logic       frame_pulse,
  output logic       bad_seg,
  output logic       an_err
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam int IW = $clog2(STALE + 1);

  bus_t          bus_d;
  bus_t          in_q;
  logic          changed;
  logic [CW-1:0] cnt;
  logic          sampled;
  logic          strobe;

  assign bus_d = {an_in, seg_in};

`ifdef SEG_CAPTURE_DP_EN
  logic dp_q;
  assign changed = (bus_d != in_q) || (dp_in != dp_q);
  always_ff @(posedge clk) begin
    if (rst) dp_q <= 1'b1;
    else     dp_q <= dp_in;
  end
`else
  assign changed = (bus_d != in_q);
`endif

  // The first cycle of a new value already counts as stable, so the
  // sample lands SETTLE cycles after in_q picks the value up.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q    <= '1;
      cnt     <= '0;
      sampled <= 1'b0;
    end else begin
      in_q <= bus_d;
      if (changed) begin
        cnt     <= CW'(1);
        sampled <= 1'b0;
      end else begin
        if (cnt != CW'(SETTLE)) cnt <= cnt + 1'b1;
        if (strobe)             sampled <= 1'b1;
      end
    end
  end

  assign strobe = (cnt == CW'(SETTLE)) && !sampled;

  logic [3:0] dec_code;
  logic       dec_valid;

  seg_pattern_decode u_decode (
    .pattern (in_q.seg),
    .code    (dec_code),
    .valid   (dec_valid)
  );

  an_class_e  an_cls;
  logic [1:0] idx;
  logic       wr;
  logic       bad;
  logic       multi;
  logic [3:0] seen;
  logic [3:0] seen_upd;
  logic       complete;
  logic [3:0] store    [4];
  logic [3:0] store_nx [4];
  logic [IW-1:0] idle_cnt;
  logic          expired;

  assign an_cls   = classify_an(in_q.an);
  assign idx      = an_index(in_q.an);
  assign wr       = strobe && (an_cls == AN_ONE) && dec_valid;
  assign bad      = strobe && (an_cls == AN_ONE) && !dec_valid;
  assign multi    = strobe && (an_cls == AN_MULTI);
  assign seen_upd = wr ? (seen | (4'b0001 << idx)) : seen;
  assign complete = wr && (seen_upd == 4'b1111);
  assign expired  = (idle_cnt == IW'(STALE));

  always_comb begin
    store_nx = store;
    if (wr) store_nx[idx] = dec_code;
  end

  // Completion takes priority over watchdog expiry in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      store       <= '{default: CODE_BLANK};
      seen        <= '0;
      idle_cnt    <= '0;
      digit3      <= CODE_BLANK;
      digit2      <= CODE_BLANK;
      digit1      <= CODE_BLANK;
      digit0      <= CODE_BLANK;
      frame_valid <= 1'b0;
      frame_pulse <= 1'b0;
      bad_seg     <= 1'b0;
      an_err      <= 1'b0;
    end else begin
      store       <= store_nx;
      frame_pulse <= complete;
      bad_seg     <= bad;
      an_err      <= multi;
      if (wr)            idle_cnt <= '0;
      else if (!expired) idle_cnt <= idle_cnt + 1'b1;
      if (complete) begin
        seen        <= '0;
        frame_valid <= 1'b1;
        digit3      <= store_nx[3];
        digit2      <= store_nx[2];
        digit1      <= store_nx[1];
        digit0      <= store_nx[0];
      end else if (wr) begin
        seen <= seen_upd;
      end else if (expired) begin
        seen        <= '0;
        frame_valid <= 1'b0;
      end
    end
  end

`ifdef SEG_CAPTURE_DP_EN
  logic [3:0] dp_store;
  logic [3:0] dp_store_nx;

  always_comb begin
    dp_store_nx = dp_store;
    if (wr) dp_store_nx[idx] = ~dp_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_store <= '0;
      dp_pos   <= '0;
    end else begin
      dp_store <= dp_store_nx;
      if (complete) dp_pos <= dp_store_nx;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg_capture.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_seg_capture : directed stimulus with an event scoreboard on the strobes
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_seg_capture;

  localparam int SETTLE = 4;
  localparam int STALE  = 300;

  localparam int K_FRAME = 0;
  localparam int K_BAD   = 1;
  localparam int K_ANERR = 2;

  localparam logic [6:0] P0    = 7'b1000000;
  localparam logic [6:0] P1    = 7'b1111001;
  localparam logic [6:0] P2    = 7'b0100100;
  localparam logic [6:0] P3    = 7'b0110000;
  localparam logic [6:0] P4    = 7'b0011001;
  localparam logic [6:0] P6    = 7'b0000010;
  localparam logic [6:0] P7    = 7'b1111000;
  localparam logic [6:0] P8    = 7'b0000000;
  localparam logic [6:0] P9    = 7'b0010000;
  localparam logic [6:0] PS    = 7'b0010010;
  localparam logic [6:0] PC    = 7'b1000110;
  localparam logic [6:0] PH    = 7'b0001011;
  localparam logic [6:0] PDASH = 7'b0111111;
  localparam logic [6:0] POFF  = 7'b1111111;
  localparam logic [6:0] PBAD  = 7'b1010101;

  typedef struct {
    int          kind;
    logic [15:0] digits;
  } ev_t;

  logic       clk;
  logic       rst;
  logic [6:0] seg_in;
  logic [3:0] an_in;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic       frame_valid, frame_pulse, bad_seg, an_err;

  int  vectors;
  int  miscompares;
  ev_t exp_q[$];
  ev_t mon_e;

  seg_capture #(.SETTLE(SETTLE), .STALE(STALE)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .digit3      (digit3),
    .digit2      (digit2),
    .digit1      (digit1),
    .digit0      (digit0),
    .frame_valid (frame_valid),
    .frame_pulse (frame_pulse),
    .bad_seg     (bad_seg),
    .an_err      (an_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    vectors++;
    miscompares++;
    $display("FAIL unexpected_%s: strobe seen with %0d events pending, expected none", name, exp_q.size());
  endtask

  task automatic push(input int kind, input logic [15:0] digits);
    ev_t e;
    e.kind   = kind;
    e.digits = digits;
    exp_q.push_back(e);
  endtask

  // Called at a falling edge; value is held for n rising edges.
  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    an_in  = a;
    seg_in = s;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] digits_now();
    return {digit3, digit2, digit1, digit0};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_pulse) begin
        if (exp_q.size() == 0) unexpected("frame_pulse");
        else begin
          mon_e = exp_q.pop_front();
          check("frame_kind", 32'(K_FRAME), 32'(mon_e.kind));
          check("frame_digits", 32'(digits_now()), 32'(mon_e.digits));
          check("frame_valid_at_pulse", 32'(frame_valid), 32'd1);
        end
      end
      if (bad_seg) begin
        if (exp_q.size() == 0) unexpected("bad_seg");
        else begin
          mon_e = exp_q.pop_front();
          check("bad_seg_kind", 32'(K_BAD), 32'(mon_e.kind));
        end
      end
      if (an_err) begin
        if (exp_q.size() == 0) unexpected("an_err");
        else begin
          mon_e = exp_q.pop_front();
          check("an_err_kind", 32'(K_ANERR), 32'(mon_e.kind));
        end
      end
    end
  end

  initial begin
    int waited;
    vectors     = 0;
    miscompares = 0;
    rst    = 1'b1;
    an_in  = 4'hF;
    seg_in = POFF;
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("reset_digits", 32'(digits_now()), 32'h0000FFFF);
    check("reset_frame_valid", 32'(frame_valid), 32'd0);

    // Loopback frame 1,2,3,4
    push(K_FRAME, 16'h1234);
    drive(4'b0111, P1, 8);
    drive(4'b1011, P2, 8);
    drive(4'b1101, P3, 8);
    drive(4'b1110, P4, 8);
    drive(4'b1111, POFF, 6);
    check("frame1_digits", 32'(digits_now()), 32'h00001234);
    check("frame1_valid", 32'(frame_valid), 32'd1);
    check("frame1_drained", 32'(exp_q.size()), 32'd0);

    // Short glitch is ignored, then S held long enough lands in position 0
    drive(4'b1110, PS, 2);
    drive(4'b1111, POFF, 6);
    drive(4'b1110, PS, 6);
    drive(4'b1111, POFF, 6);

    // Unknown pattern at position 1
    push(K_BAD, 16'h0000);
    drive(4'b1101, PBAD, 6);
    drive(4'b1111, POFF, 6);

    // Two anodes active
    push(K_ANERR, 16'h0000);
    drive(4'b1100, P8, 6);
    drive(4'b1111, POFF, 6);
    check("errors_drained", 32'(exp_q.size()), 32'd0);

    // Position 1 must still be missing: frame completes only on its write
    drive(4'b1011, P7, 8);
    drive(4'b0111, PC, 8);
    push(K_FRAME, 16'hC7D5);
    drive(4'b1101, PH, 8);
    drive(4'b1111, POFF, 6);
    check("frame2_digits", 32'(digits_now()), 32'h0000C7D5);

    // Rewrite position 0 (last wins), O as 0, blank digit
    drive(4'b1110, P9, 8);
    drive(4'b1110, PDASH, 8);
    drive(4'b0111, P0, 8);
    drive(4'b1011, POFF, 8);
    push(K_FRAME, 16'h0F6E);
    drive(4'b1101, P6, 8);

    // Watchdog
    drive(4'b1111, POFF, 50);
    check("valid_before_stale", 32'(frame_valid), 32'd1);
    waited = 0;
    while (frame_valid && waited < STALE + 50) begin
      @(negedge clk);
      waited++;
    end
    check("watchdog_drop", 32'(frame_valid), 32'd0);
    check("watchdog_not_early", 32'(waited + 60 >= STALE), 32'd1);
    check("digits_hold_after_stale", 32'(digits_now()), 32'h00000F6E);
    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
